spi_flash_reader: RTL and testbench
===================================

Name: spi_flash_reader

Overview:
- Wishbone-slave SPI flash read initiator for the user project area.
- Turns a 32-bit Wishbone read into a standard SPI READ (0x03) transaction and returns the word.
- Drives the flash pins that the spiflash simulation model responds to, so one testbench can exercise it end-to-end.
- Read-only. Writes are acknowledged and ignored.

Parameters:
- CLK_DIV, 2: SCLK half-period in wb_clk_i cycles; must be ≥1.
- CS_HIGH_CYCLES, 4: minimum CSB-high cycles between transactions; must be ≥1.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  synchronous active-high reset.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects; ignored.
- wbs_adr_i  in  32  byte address; bits [23:2] used.
- wbs_dat_i  in  32  write data; ignored.
- wbs_ack_o  out  1  one-cycle acknowledge.
- wbs_dat_o  out  32  read data.
- flash_csb_o  out  1  chip select, active low.
- flash_clk_o  out  1  SPI clock, mode 0.
- flash_mosi_o  out  1  serial data to flash (io0).
- flash_miso_i  in  1  serial data from flash (io1).
- busy_o  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values: wbs_ack_o=0, wbs_dat_o=0, flash_csb_o=1, flash_clk_o=0, flash_mosi_o=0, busy_o=0, state=IDLE.
- Reset is synchronous and takes priority over everything, including mid-transaction. All outputs reach reset values on the next edge. No ack is issued for an aborted request.
- States: IDLE, SHIFT, DONE, GAP.
- IDLE, accepting a request: on stb&cyc with ack low.
  - Write (we=1): ack=1 next cycle. No flash activity, wbs_dat_o unchanged, stay in IDLE.
  - Read: latch flash address {adr[23:2],2'b00} and the 64-bit shift word {8'h03, addr24, 32'h0}. Go to SHIFT.
- SHIFT:
  - On the first SHIFT cycle, csb=0, clk=0, and mosi = shift word bit 63.
  - clk toggles every CLK_DIV cycles.
  - Rising edge: sample miso into the receive register.
  - Falling edge: advance mosi to the next bit, MSB first.
  - The 6-bit counter counts rising edges. After the 64th rising edge, the following falling edge moves to DONE with clk=0.
- Data assembly: 32 received bits arrive as bytes B0..B3, each MSB first. wbs_dat_o = {B3,B2,B1,B0} (little-endian; B0 is flash byte at addr).
- DONE: lasts one cycle. csb=1, ack=1, wbs_dat_o updated. Go to GAP.
- GAP: csb held high for CS_HIGH_CYCLES cycles counted from DONE inclusive, then IDLE. Requests arriving during GAP wait; stb stays asserted by the master.
- Read latency: stb sampled in IDLE at cycle T gives ack at cycle T+1+128·CLK_DIV. This is 257 for CLK_DIV=2.
- Abort: cyc dropped during SHIFT gives csb=1, clk=0 next cycle, no ack, go to GAP, wbs_dat_o unchanged.
- wbs_dat_o holds its value between reads. Ack is never asserted for two consecutive cycles.
- Bit counter wrap: counter reaching 63 must not wrap into an extra bit. Exactly 64 SCLK rising edges per transaction.

Decomposition:
- Shared package spi_flash_pkg:
  - state enum (IDLE/SHIFT/DONE/GAP);
  - READ_OPCODE=8'h03;
  - XFER_BITS=64;
  - ADDR_BITS=24.
- One sub-module, spi_sclk_gen: CLK_DIV divider. Outputs flash_clk_o plus one-cycle rise_stb/fall_stb pulses. Enabled only in SHIFT, and clears to clk=0 when disabled.

Test Plan:
- Flash bytes 0x11,0x22,0x33,0x44 at 0x000100; read adr 0x00000100 → ack exactly 257 cycles after stb; dat_o=0x44332211. Captured MOSI bytes 0x03,0x00,0x01,0x00. Exactly 64 SCLK rising edges, csb low throughout.
- Read adr 0x00000102 → flash address sent 0x000100; same data 0x44332211.
- Write to any address → ack the cycle after stb; csb, clk and mosi never toggle; prior dat_o unchanged.
- Two back-to-back reads, stb held → csb high for ≥4 cycles between transactions; both acks single-cycle; correct data for each.
- wb_rst_i pulsed 100 cycles into a read → next edge csb=1, clk=0, ack=0, dat_o=0; no ack for the aborted read; a following read returns correct data.
- CLK_DIV=1 build: read latency 129 cycles; cyc dropped mid-read → csb high next cycle, no ack, busy_o low after 4 cycles.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash read initiator.
package spi_flash_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic [7:0] READ_OPCODE = 8'h03;
  localparam int         XFER_BITS   = 64;
  localparam int         ADDR_BITS   = 24;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: toggles every CLK_DIV cycles while enabled, parks low otherwise.
module spi_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_sclk,
  output logic o_rise_stb,
  output logic o_fall_stb
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_sclk;
  logic          w_tick;

  assign w_tick = i_en && (r_cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (w_tick) begin
      r_cnt  <= '0;
      r_sclk <= ~r_sclk;
    end else begin
      r_cnt  <= r_cnt + CW'(1);
    end
  end

  // Strobes mark the system edge on which SCLK is about to change.
  assign o_sclk     = r_sclk;
  assign o_rise_stb = w_tick & ~r_sclk;
  assign o_fall_stb = w_tick &  r_sclk;

endmodule

// File: rtl/spi_flash_reader.sv
// Wishbone slave that turns a 32-bit read into an SPI READ (0x03) and returns
// the word little-endian. Writes are acknowledged and dropped.
//
// state | meaning
// IDLE  | waiting for a Wishbone request
// SHIFT | CSB low, 64 SCLK periods of opcode/address out, data in
// DONE  | one cycle, ack high, read data valid
// GAP   | CSB held high before the next transaction may start
module spi_flash_reader #(
  parameter int CLK_DIV        = 2,
  parameter int CS_HIGH_CYCLES = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        flash_csb_o,
  output logic        flash_clk_o,
  output logic        flash_mosi_o,
  input  logic        flash_miso_i,
  output logic        busy_o
);

  import spi_flash_pkg::*;

  state_t                 r_state;
  logic [XFER_BITS-2:0]   r_shift;
  logic [31:0]            r_rx;
  logic [5:0]             r_bit_cnt;
  logic                   r_last;
  logic [7:0]             r_gap_cnt;
  logic                   r_ack;
  logic [31:0]            r_dat;
  logic                   r_csb;
  logic                   r_mosi;

  logic                   w_sclk_en;
  logic                   w_rise;
  logic                   w_fall;
  logic [ADDR_BITS-1:0]   w_addr;
  logic [XFER_BITS-1:0]   w_word;
  logic                   w_unused;

  assign w_addr    = {wbs_adr_i[23:2], 2'b00};
  assign w_word    = {READ_OPCODE, w_addr, 32'h0};
  assign w_sclk_en = (r_state == SHIFT) && wbs_cyc_i;
  assign w_unused  = ^{wbs_sel_i, wbs_dat_i, wbs_adr_i[31:24], wbs_adr_i[1:0]};

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .i_clk      (wb_clk_i),
    .i_rst      (wb_rst_i),
    .i_en       (w_sclk_en),
    .o_sclk     (flash_clk_o),
    .o_rise_stb (w_rise),
    .o_fall_stb (w_fall)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_rx      <= '0;
      r_bit_cnt <= '0;
      r_last    <= 1'b0;
      r_gap_cnt <= '0;
      r_ack     <= 1'b0;
      r_dat     <= '0;
      r_csb     <= 1'b1;
      r_mosi    <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (wbs_stb_i && wbs_cyc_i && !r_ack) begin
            if (wbs_we_i) begin
              r_ack <= 1'b1;
            end else begin
              r_shift   <= w_word[XFER_BITS-2:0];
              r_mosi    <= w_word[XFER_BITS-1];
              r_csb     <= 1'b0;
              r_bit_cnt <= '0;
              r_last    <= 1'b0;
              r_state   <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (!wbs_cyc_i) begin
            r_csb     <= 1'b1;
            r_mosi    <= 1'b0;
            r_gap_cnt <= 8'(CS_HIGH_CYCLES - 1);
            r_state   <= GAP;
          end else if (w_rise) begin
            r_rx <= {r_rx[30:0], flash_miso_i};
            // Saturate on the final bit so the count never wraps into a 65th.
            if (r_bit_cnt == 6'(XFER_BITS - 1))
              r_last <= 1'b1;
            else
              r_bit_cnt <= r_bit_cnt + 6'd1;
          end else if (w_fall) begin
            if (r_last) begin
              r_csb   <= 1'b1;
              r_mosi  <= 1'b0;
              r_ack   <= 1'b1;
              r_dat   <= {r_rx[7:0], r_rx[15:8], r_rx[23:16], r_rx[31:24]};
              r_state <= DONE;
            end else begin
              r_mosi  <= r_shift[XFER_BITS-2];
              r_shift <= {r_shift[XFER_BITS-3:0], 1'b0};
            end
          end
        end
        DONE: begin
          if (CS_HIGH_CYCLES > 1) begin
            r_gap_cnt <= 8'(CS_HIGH_CYCLES - 2);
            r_state   <= GAP;
          end else begin
            r_state   <= IDLE;
          end
        end
        GAP: begin
          if (r_gap_cnt == 8'd0)
            r_state <= IDLE;
          else
            r_gap_cnt <= r_gap_cnt - 8'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign wbs_ack_o    = r_ack;
  assign wbs_dat_o    = r_dat;
  assign flash_csb_o  = r_csb;
  assign flash_mosi_o = r_mosi;
  assign busy_o       = (r_state != IDLE);

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench: a CLK_DIV=2 instance against a behavioural SPI flash and a
// CLK_DIV=1 instance with MISO tied high for latency and abort behaviour.
module tb_spi_flash_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb0 = 1'b0, cyc0 = 1'b0, stb1 = 1'b0, cyc1 = 1'b0;
  logic        wb_we = 1'b0;
  logic [31:0] wb_adr = '0, wb_dat_i = '0;
  logic        ack0, csb0, fclk0, mosi0, busy0;
  logic        ack1, csb1, fclk1, mosi1, busy1;
  logic [31:0] dat0, dat1;
  logic        miso0 = 1'b0;
  logic        miso1 = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spi_flash_reader #(.CLK_DIV(2), .CS_HIGH_CYCLES(4)) u_dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb0), .wbs_cyc_i(cyc0),
    .wbs_we_i(wb_we), .wbs_sel_i(4'hF), .wbs_adr_i(wb_adr), .wbs_dat_i(wb_dat_i),
    .wbs_ack_o(ack0), .wbs_dat_o(dat0), .flash_csb_o(csb0), .flash_clk_o(fclk0),
    .flash_mosi_o(mosi0), .flash_miso_i(miso0), .busy_o(busy0)
  );

  spi_flash_reader #(.CLK_DIV(1), .CS_HIGH_CYCLES(4)) u_dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb1), .wbs_cyc_i(cyc1),
    .wbs_we_i(wb_we), .wbs_sel_i(4'hF), .wbs_adr_i(wb_adr), .wbs_dat_i(wb_dat_i),
    .wbs_ack_o(ack1), .wbs_dat_o(dat1), .flash_csb_o(csb1), .flash_clk_o(fclk1),
    .flash_mosi_o(mosi1), .flash_miso_i(miso1), .busy_o(busy1)
  );

  // Behavioural SPI flash, mode 0, READ command only.
  logic [63:0] m_cap = '0;
  logic [23:0] m_addr = '0;
  int m_rises = 0, n_rise_tot = 0, n_csb_fall = 0, n_csb_rise = 0, n_mosi_chg = 0;

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    case (a)
      24'h000100: return 8'h11;
      24'h000101: return 8'h22;
      24'h000102: return 8'h33;
      24'h000103: return 8'h44;
      24'h000104: return 8'h55;
      24'h000105: return 8'h66;
      24'h000106: return 8'h77;
      24'h000107: return 8'h88;
      default:    return 8'hA5;
    endcase
  endfunction

  always @(negedge csb0) begin
    m_cap = '0;
    m_rises = 0;
    n_csb_fall++;
  end
  always @(posedge csb0) n_csb_rise++;
  always @(mosi0) n_mosi_chg++;

  always @(posedge fclk0) begin
    n_rise_tot++;
    if (csb0 === 1'b0) begin
      m_cap = {m_cap[62:0], mosi0};
      m_rises++;
      if (m_rises == 32) m_addr = m_cap[23:0];
    end
  end

  always @(negedge fclk0) begin
    logic [7:0] b;
    int idx;
    if (csb0 === 1'b0 && m_rises >= 32 && m_rises < 64) begin
      idx   = m_rises - 32;
      b     = flash_byte(m_addr + 24'(idx / 8));
      miso0 = b[7 - (idx % 8)];
    end
  end

  task automatic chk_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Latency counts negedge samples after the edge that accepts the strobe.
  task automatic wb_xfer(input bit u, input logic [31:0] adr, input bit we, input bit hold,
                         output logic [31:0] dat, output int lat);
    logic got;
    repeat (8) @(negedge clk);
    wb_adr   = adr;
    wb_we    = we;
    wb_dat_i = 32'hDEADBEEF;
    if (u) begin stb1 = 1'b1; cyc1 = 1'b1; end
    else   begin stb0 = 1'b1; cyc0 = 1'b1; end
    @(posedge clk);
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      lat++;
      got = u ? ack1 : ack0;
    end
    if (got !== 1'b1) chk_val("xfer_timeout", 0, 1);
    dat = u ? dat1 : dat0;
    chk_val("csb_at_ack", u ? csb1 : csb0, 1);
    if (!hold) begin
      if (u) begin stb1 = 1'b0; cyc1 = 1'b0; end
      else   begin stb0 = 1'b0; cyc0 = 1'b0; end
    end
    @(negedge clk);
    chk_val("ack_single", u ? ack1 : ack0, 0);
  endtask

  initial begin
    logic [31:0] d;
    int lat, fall0, rise0, tot0, mchg0, gap, acks;
    logic got;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_val("rst_ack",  ack0,  0);
    chk_val("rst_dat",  dat0,  0);
    chk_val("rst_csb",  csb0,  1);
    chk_val("rst_clk",  fclk0, 0);
    chk_val("rst_mosi", mosi0, 0);
    chk_val("rst_busy", busy0, 0);

    fall0 = n_csb_fall; rise0 = n_csb_rise; tot0 = n_rise_tot;
    wb_xfer(0, 32'h0000_0100, 0, 0, d, lat);
    chk_val("rd0_latency", lat, 257);
    chk_val("rd0_data", d, 32'h44332211);
    chk_val("rd0_mosi", m_cap[63:32], 32'h03000100);
    chk_val("rd0_rises", m_rises, 64);
    chk_val("rd0_rises_total", n_rise_tot - tot0, 64);
    chk_val("rd0_csb_fall", n_csb_fall - fall0, 1);
    chk_val("rd0_csb_rise", n_csb_rise - rise0, 1);

    wb_xfer(0, 32'h0000_0102, 0, 0, d, lat);
    chk_val("rd1_data", d, 32'h44332211);
    chk_val("rd1_mosi", m_cap[63:32], 32'h03000100);

    fall0 = n_csb_fall; tot0 = n_rise_tot; mchg0 = n_mosi_chg;
    wb_xfer(0, 32'h0000_0104, 1, 0, d, lat);
    repeat (10) @(negedge clk);
    chk_val("wr_latency", lat, 1);
    chk_val("wr_dat_kept", dat0, 32'h44332211);
    chk_val("wr_csb_quiet", n_csb_fall - fall0, 0);
    chk_val("wr_clk_quiet", n_rise_tot - tot0, 0);
    chk_val("wr_mosi_quiet", n_mosi_chg - mchg0, 0);
    chk_val("wr_busy", busy0, 0);

    wb_xfer(0, 32'h0000_0100, 0, 1, d, lat);
    chk_val("b2b_first", d, 32'h44332211);
    wb_adr = 32'h0000_0104;
    gap = 2;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (csb0) gap++;
      else break;
    end
    chk_val("b2b_gap_ge4", (gap >= 4), 1);
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      got = ack0;
    end
    chk_val("b2b_second_ack", got, 1);
    chk_val("b2b_second", dat0, 32'h88776655);
    stb0 = 1'b0; cyc0 = 1'b0;
    @(negedge clk);
    chk_val("b2b_ack_single", ack0, 0);

    repeat (8) @(negedge clk);
    wb_adr = 32'h0000_0104; wb_we = 1'b0; stb0 = 1'b1; cyc0 = 1'b1;
    repeat (100) @(negedge clk);
    chk_val("rstmid_busy", busy0, 1);
    rst = 1'b1;
    @(negedge clk);
    chk_val("rstmid_csb",  csb0,  1);
    chk_val("rstmid_clk",  fclk0, 0);
    chk_val("rstmid_ack",  ack0,  0);
    chk_val("rstmid_dat",  dat0,  0);
    chk_val("rstmid_busy_low", busy0, 0);
    rst = 1'b0; stb0 = 1'b0; cyc0 = 1'b0;
    acks = 0;
    repeat (300) begin
      @(negedge clk);
      if (ack0) acks++;
    end
    chk_val("rstmid_no_ack", acks, 0);
    wb_xfer(0, 32'h0000_0100, 0, 0, d, lat);
    chk_val("rstmid_recover", d, 32'h44332211);

    wb_xfer(1, 32'h0000_0100, 0, 0, d, lat);
    chk_val("div1_latency", lat, 129);
    chk_val("div1_data", d, 32'hFFFFFFFF);

    repeat (8) @(negedge clk);
    wb_adr = 32'h0000_0100; wb_we = 1'b0; stb1 = 1'b1; cyc1 = 1'b1;
    repeat (20) @(negedge clk);
    chk_val("abort_busy_pre", busy1, 1);
    chk_val("abort_csb_pre", csb1, 0);
    stb1 = 1'b0; cyc1 = 1'b0;
    @(negedge clk);
    chk_val("abort_csb", csb1, 1);
    chk_val("abort_clk", fclk1, 0);
    acks = ack1 ? 1 : 0;
    repeat (3) begin
      @(negedge clk);
      if (ack1) acks++;
    end
    chk_val("abort_busy_a3", busy1, 1);
    @(negedge clk);
    if (ack1) acks++;
    chk_val("abort_busy_a4", busy1, 0);
    repeat (20) begin
      @(negedge clk);
      if (ack1) acks++;
    end
    chk_val("abort_no_ack", acks, 0);
    chk_val("abort_dat_kept", dat1, 32'hFFFFFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
